// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - load/store op codes, FSM states and lane helpers for mem_access_unit
// ACC2/RD2 exist only when MEM_ACCESS_MISALIGN_SPLIT_EN is defined.
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9,
        OP_INV = 4'd15
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ACC1,
        RD1,
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        ACC2,
        RD2,
`endif
        RESP
    } state_t;

    localparam int         LANES   = 4;
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    function automatic mem_op_t mips_to_mem_op(input logic [5:0] opcode);
        case (opcode)
            6'h20:   return OP_LB;
            6'h21:   return OP_LH;
            6'h22:   return OP_LWL;
            6'h23:   return OP_LW;
            6'h24:   return OP_LBU;
            6'h25:   return OP_LHU;
            6'h26:   return OP_LWR;
            6'h28:   return OP_SB;
            6'h29:   return OP_SH;
            6'h2B:   return OP_SW;
            default: return OP_INV;
        endcase
    endfunction

    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic op_valid(input mem_op_t op);
        return op <= OP_SW;
    endfunction

    function automatic logic op_store(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] k);
        case (op)
            OP_LH, OP_LHU, OP_SH: return k[0];
            OP_LW, OP_SW:         return k != 2'd0;
            default:              return 1'b0;
        endcase
    endfunction

    // LWL/LWR are partial-word by definition and never leave their word
    function automatic logic op_crosses(input mem_op_t op, input logic [1:0] k);
        if (op == OP_LWL || op == OP_LWR) return 1'b0;
        return ({2'b00, k} + {1'b0, op_size(op)}) > 4'd4;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable, store shift, load extend and LWL/LWR merge datapath
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [3:0]  op,
    input  logic [1:0]  k,
    input  logic [31:0] rt,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    output logic [3:0]  be1,
    output logic [3:0]  be2,
    output logic [31:0] wd1,
    output logic [31:0] wd2,
    output logic [31:0] rdata
);

    mem_op_t     opc;
    logic [2:0]  n;
    logic [2:0]  sh;
    logic [31:0] nmask;
    logic [63:0] spos;
    logic [7:0]  be64;
    logic [63:0] win;
    logic [31:0] wext;
    logic [31:0] wl;
    logic [4:0]  lsh;
    logic [3:0]  lbe;

    // The access is placed in a two-word window; first word is low-order for
    // little-endian and high-order for big-endian, so one shift serves both.
    always_comb begin
        opc   = mem_op_t'(op);
        n     = op_size(opc);
        sh    = (BIG_ENDIAN != 0) ? 3'(4'd8 - {2'b00, k} - {1'b0, n}) : {1'b0, k};
        nmask = (n == 3'd1) ? 32'h0000_00FF : (n == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        spos  = {32'h0, rt & nmask} << {sh, 3'b000};
        be64  = {4'b0000, nmask[24], nmask[16], nmask[8], nmask[0]} << sh;
        win   = (BIG_ENDIAN != 0) ? {w1, w2} : {w2, w1};
        wext  = 32'(win >> {sh, 3'b000});
        wl    = (BIG_ENDIAN != 0) ? {w1[7:0], w1[15:8], w1[23:16], w1[31:24]} : w1;
        lsh   = {~k, 3'b000};
        lbe   = BE_NONE;
        be1   = (BIG_ENDIAN != 0) ? be64[7:4]    : be64[3:0];
        be2   = (BIG_ENDIAN != 0) ? be64[3:0]    : be64[7:4];
        wd1   = (BIG_ENDIAN != 0) ? spos[63:32]  : spos[31:0];
        wd2   = (BIG_ENDIAN != 0) ? spos[31:0]   : spos[63:32];
        case (opc)
            OP_LB:   rdata = {{24{wext[7]}}, wext[7:0]};
            OP_LBU:  rdata = {24'h0, wext[7:0]};
            OP_LH:   rdata = {{16{wext[15]}}, wext[15:0]};
            OP_LHU:  rdata = {16'h0, wext[15:0]};
            OP_LWL: begin
                rdata = (wl << lsh) | (rt & ~(32'hFFFF_FFFF << lsh));
                lbe   = BE_ALL >> ~k;
            end
            OP_LWR: begin
                rdata = (wl >> {k, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {k, 3'b000}));
                lbe   = BE_ALL << k;
            end
            default: rdata = wext;
        endcase
        if (lbe != BE_NONE) begin
            be1 = (BIG_ENDIAN != 0) ? {lbe[0], lbe[1], lbe[2], lbe[3]} : lbe;
            be2 = BE_NONE;
            wd1 = 32'h0;
            wd2 = 32'h0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving a wait-request data bus
// MEM_ACCESS_MISALIGN_SPLIT_EN splits word-crossing halfword/word accesses in two.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata
);

    state_t            state;
    state_t            state_n;
    mem_op_t           op_q;
    mem_op_t           req_opc;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       rt_q;
    logic [31:0]       w1_q;
    logic [31:0]       w1_n;
    logic [31:0]       w2_n;
    logic [31:0]       rdata_q;
    logic [31:0]       ld_data;
    logic              err_q;
    logic              req_bad;
    logic              is_store;
    logic [3:0]        be1;
    logic [3:0]        be2;
    logic [31:0]       wd1;
    logic [31:0]       wd2;

    assign req_opc   = mem_op_t'(req_op);
    assign is_store  = op_store(op_q);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    // Load data is formed from the word arriving this cycle so it can be registered into RESP
    assign w1_n      = (state == RD1) ? mem_readdata : w1_q;

`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    logic [31:0] w2_q;
    logic        split;
    assign req_bad = !op_valid(req_opc);
    assign split   = op_crosses(op_q, addr_q[1:0]);
    assign w2_n    = (state == RD2) ? mem_readdata : w2_q;
`else
    logic unused_second;
    assign req_bad       = !op_valid(req_opc) || op_misaligned(req_opc, req_addr[1:0]);
    assign w2_n          = 32'h0;
    assign unused_second = ^{be2, wd2};
`endif

    mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .op    (op_q),
        .k     (addr_q[1:0]),
        .rt    (rt_q),
        .w1    (w1_n),
        .w2    (w2_n),
        .be1   (be1),
        .be2   (be2),
        .wd1   (wd1),
        .wd2   (wd2),
        .rdata (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_LB;
            addr_q  <= '0;
            rt_q    <= 32'h0;
            err_q   <= 1'b0;
            w1_q    <= 32'h0;
            rdata_q <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            w2_q    <= 32'h0;
`endif
        end else begin
            state <= state_n;
            if (req_valid && req_ready) begin
                op_q   <= req_opc;
                addr_q <= req_addr;
                rt_q   <= req_rt;
                err_q  <= req_bad;
            end
            if (state == RD1) w1_q <= mem_readdata;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            if (state == RD2) w2_q <= mem_readdata;
`endif
            if (state_n == RESP) begin
                rdata_q <= (state == IDLE || is_store) ? 32'h0 : ld_data;
            end
        end
    end

    always_comb begin
        state_n        = state;
        req_ready      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = BE_NONE;
        mem_writedata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = req_bad ? RESP : ACC1;
            end
            ACC1: begin
                mem_read       = !is_store;
                mem_write      = is_store;
                mem_address    = word_addr;
                mem_byteenable = be1;
                mem_writedata  = is_store ? wd1 : 32'h0;
                if (!mem_waitrequest) begin
                    if (!is_store) state_n = RD1;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
                    else if (split) state_n = ACC2;
`endif
                    else state_n = RESP;
                end
            end
            RD1: begin
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
                state_n = split ? ACC2 : RESP;
`else
                state_n = RESP;
`endif
            end
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            ACC2: begin
                mem_read       = !is_store;
                mem_write      = is_store;
                mem_address    = word_addr + ADDR_W'(4);
                mem_byteenable = be2;
                mem_writedata  = is_store ? wd2 : 32'h0;
                if (!mem_waitrequest) state_n = is_store ? RESP : RD2;
            end
            RD2: state_n = RESP;
`endif
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_rt = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata;
    logic [31:0] rd_addr_q = 32'h0;

    logic        be_req_valid = 1'b0;
    logic        be_req_ready;
    logic [3:0]  be_req_op = 4'd0;
    logic [31:0] be_req_addr = 32'h0;
    logic [31:0] be_req_rt = 32'h0;
    logic        be_resp_valid;
    logic [31:0] be_resp_rdata;
    logic        be_resp_err;
    logic [31:0] be_mem_address;
    logic        be_mem_read;
    logic        be_mem_write;
    logic [3:0]  be_mem_byteenable;
    logic [31:0] be_mem_writedata;
    logic        be_mem_waitrequest = 1'b0;
    logic [31:0] be_mem_readdata = 32'h0;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wd[$];
    logic        log_wr[$];

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
    );

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .reset(reset), .req_valid(be_req_valid), .req_ready(be_req_ready),
        .req_op(be_req_op), .req_addr(be_req_addr), .req_rt(be_req_rt),
        .resp_valid(be_resp_valid), .resp_rdata(be_resp_rdata), .resp_err(be_resp_err),
        .mem_address(be_mem_address), .mem_read(be_mem_read), .mem_write(be_mem_write),
        .mem_byteenable(be_mem_byteenable), .mem_writedata(be_mem_writedata),
        .mem_waitrequest(be_mem_waitrequest), .mem_readdata(be_mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h1000: return 32'h80FF_0000;
            32'h3000: return 32'h4433_2211;
            32'h4000: return 32'h4433_2211;
            32'h4004: return 32'h8877_6655;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) if (mem_read && !mem_waitrequest) rd_addr_q <= mem_address;
    assign mem_readdata = mem_word(rd_addr_q);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input int waits, output int lat, output logic [31:0] rd, output logic er);
        int w;
        w = waits;
        lat = -1;
        rd = 32'h0;
        er = 1'b0;
        log_addr.delete(); log_be.delete(); log_wd.delete(); log_wr.delete();
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_rt = rt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                log_addr.push_back(mem_address);
                log_be.push_back(mem_byteenable);
                log_wd.push_back(mem_writedata);
                log_wr.push_back(mem_write);
                mem_waitrequest = (w > 0);
                if (w > 0) w--;
            end else begin
                mem_waitrequest = 1'b0;
            end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
            end
        end
        mem_waitrequest = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic        saw;
        #1 reset = 1'b1;
        #11;
        check("rst_ready", req_ready, 1);
        check("rst_flags", {resp_valid, resp_err, mem_read, mem_write}, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_addr", mem_address, 0);
        check("rst_be", mem_byteenable, 0);
        check("rst_wd", mem_writedata, 0);
        @(negedge clk);
        reset = 1'b0;

        do_req(OP_LB, 32'h1003, 32'h0, 0, lat, rd, er);
        check("lb_lat", lat, 3);
        check("lb_data", rd, 32'hFFFF_FF80);
        check("lb_ncmd", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check("lb_addr", log_addr[0], 32'h1000);
            check("lb_be", log_be[0], 4'b1000);
            check("lb_rd", log_wr[0], 0);
        end

        do_req(OP_LBU, 32'h1003, 32'h0, 0, lat, rd, er);
        check("lbu_data", rd, 32'h0000_0080);

        do_req(OP_LH, 32'h1002, 32'h0, 0, lat, rd, er);
        check("lh_data", rd, 32'hFFFF_80FF);
        do_req(OP_LHU, 32'h3002, 32'h0, 0, lat, rd, er);
        check("lhu_data", rd, 32'h0000_4433);

        do_req(OP_SH, 32'h2002, 32'h1234_ABCD, 2, lat, rd, er);
        check("sh_lat", lat, 4);
        check("sh_ncmd", log_addr.size(), 3);
        for (int i = 0; i < log_addr.size(); i++) begin
            check($sformatf("sh_addr%0d", i), log_addr[i], 32'h2000);
            check($sformatf("sh_be%0d", i), log_be[i], 4'b1100);
            check($sformatf("sh_wd%0d", i), log_wd[i], 32'hABCD_0000);
            check($sformatf("sh_wr%0d", i), log_wr[i], 1);
        end
        check("sh_rdata", rd, 0);

        do_req(OP_SW, 32'h5000, 32'hCAFE_F00D, 0, lat, rd, er);
        check("sw_lat", lat, 2);
        if (log_addr.size() == 1) check("sw_wd", log_wd[0], 32'hCAFE_F00D);
        else check("sw_ncmd", log_addr.size(), 1);

        do_req(OP_LWL, 32'h3001, 32'hAABB_CCDD, 0, lat, rd, er);
        check("lwl_data", rd, 32'h2211_CCDD);
        if (log_be.size() == 1) check("lwl_be", log_be[0], 4'b0011);
        else check("lwl_ncmd", log_be.size(), 1);
        do_req(OP_LWR, 32'h3001, 32'hAABB_CCDD, 0, lat, rd, er);
        check("lwr_data", rd, 32'hAA44_3322);
        if (log_be.size() == 1) check("lwr_be", log_be[0], 4'b1110);
        else check("lwr_ncmd", log_be.size(), 1);
        repeat (3) @(negedge clk);
        check("rdata_hold", resp_rdata, 32'hAA44_3322);

        do_req(OP_LW, 32'h4002, 32'h0, 0, lat, rd, er);
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        check("lwsplit_lat", lat, 5);
        check("lwsplit_data", rd, 32'h6655_4433);
        check("lwsplit_err", er, 0);
        check("lwsplit_ncmd", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("lwsplit_be0", log_be[0], 4'b1100);
            check("lwsplit_a0", log_addr[0], 32'h4000);
            check("lwsplit_be1", log_be[1], 4'b0011);
            check("lwsplit_a1", log_addr[1], 32'h4004);
        end
`else
        check("lwmis_lat", lat, 1);
        check("lwmis_err", er, 1);
        check("lwmis_data", rd, 0);
        check("lwmis_ncmd", log_addr.size(), 0);
`endif

        do_req(4'd12, 32'h1000, 32'h0, 0, lat, rd, er);
        check("badop_lat", lat, 1);
        check("badop_err", er, 1);
        check("badop_ncmd", log_addr.size(), 0);

        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h1000; mem_waitrequest = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_read_on", mem_read, 1);
        #2 reset = 1'b1;
        #1 check("abort_read_off", mem_read, 0);
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw = saw | resp_valid;
        end
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw = saw | resp_valid;
        end
        check("abort_noresp", saw, 0);
        check("abort_ready", req_ready, 1);

        @(negedge clk);
        be_req_valid = 1'b1; be_req_op = OP_SB; be_req_addr = 32'h6000; be_req_rt = 32'h0000_005A;
        @(posedge clk);
        #1 be_req_valid = 1'b0;
        @(negedge clk);
        check("be_sb_wr", be_mem_write, 1);
        check("be_sb_addr", be_mem_address, 32'h6000);
        check("be_sb_be", be_mem_byteenable, 4'b1000);
        check("be_sb_wd", be_mem_writedata, 32'h5A00_0000);
        @(negedge clk);
        check("be_sb_resp", be_resp_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
